// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 1-to-4 demultiplexer.
// Optional feature macro used by the top: DEMUX_STALL_CNT_EN.
package demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    // Lane index / round-robin pointer
    typedef logic [SEL_W-1:0] lane_idx_t;

    // Saturating stall counter
    typedef logic [7:0] stall_cnt_t;

    localparam stall_cnt_t STALL_MAX = 8'hFF;

endpackage

// File: rtl/demux_1_4_buf_lane.sv
// Single output lane: data register plus occupancy flag.
// EMPTY -> FULL on write, FULL -> EMPTY on ack without write,
// FULL -> FULL on write+ack. Data is held (not cleared) on ack.
module demux_lane_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    // Lane storage: a write wins over an ack, so write+ack keeps the lane full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (wr) begin
            q     <= d;
            valid <= 1'b1;
        end else if (ack) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_4_buf.sv
// Buffered 1-to-4 demultiplexer with explicit or round-robin lane selection
// and per-lane ack-based backpressure.
// Optional feature: define DEMUX_STALL_CNT_EN to add a saturating stall
// counter (stall_cnt output, stall_clr input).
module demux_1_4_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int LANES = demux_pkg::LANES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       I,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       S,
    input  logic                   auto_mode,
    output logic [LANES*WIDTH-1:0] Y,
    output logic [LANES-1:0]       lane_valid,
    input  logic [LANES-1:0]       lane_ack,
`ifdef DEMUX_STALL_CNT_EN
    input  logic                   stall_clr,
    output logic [7:0]             stall_cnt,
`endif
    output logic [SEL_W-1:0]       ptr
);

    lane_idx_t        tgt;
    lane_idx_t        rr_ptr;
    logic             accept;
    logic [LANES-1:0] wr;

    // Target lane, ready and per-lane write strobes; a lane acked this cycle is writable
    always_comb begin
        wr       = '0;
        tgt      = auto_mode ? rr_ptr : lane_idx_t'(S);
        in_ready = ~lane_valid[tgt] | lane_ack[tgt];
        accept   = in_valid & in_ready;
        if (accept) begin
            wr[tgt] = 1'b1;
        end
    end

    // Round-robin pointer advances only on accepts made in auto mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && auto_mode) begin
            rr_ptr <= rr_ptr + 2'd1;
        end
    end

    assign ptr = rr_ptr;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        demux_lane_reg #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (wr[gi]),
            .ack   (lane_ack[gi]),
            .d     (I),
            .q     (Y[gi*WIDTH +: WIDTH]),
            .valid (lane_valid[gi])
        );
    end

`ifdef DEMUX_STALL_CNT_EN
    stall_cnt_t stall_q;

    // Saturating count of cycles where the source is blocked; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stall_clr) begin
            stall_q <= '0;
        end else if (in_valid && !in_ready && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + 8'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_demux_1_4_buf.sv
// Directed testbench for demux_1_4_buf (WIDTH=4).
// Covers the DEMUX_STALL_CNT_EN counter when that macro is defined.
module tb_demux_1_4_buf;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  I = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    S = '0;
    logic          auto_mode = 1'b0;
    logic [4*W-1:0] Y;
    logic [3:0]    lane_valid;
    logic [3:0]    lane_ack = '0;
    logic [1:0]    ptr;
`ifdef DEMUX_STALL_CNT_EN
    logic          stall_clr = 1'b0;
    logic [7:0]    stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_1_4_buf #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .I          (I),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .S          (S),
        .auto_mode  (auto_mode),
        .Y          (Y),
        .lane_valid (lane_valid),
        .lane_ack   (lane_ack),
`ifdef DEMUX_STALL_CNT_EN
        .stall_clr  (stall_clr),
        .stall_cnt  (stall_cnt),
`endif
        .ptr        (ptr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (Y !== 16'h0000) begin errors++; $display("FAIL reset_Y got %h expected %h", Y, 16'h0000); end
        checks++; if (lane_valid !== 4'b0000) begin errors++; $display("FAIL reset_lane_valid got %b expected %b", lane_valid, 4'b0000); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d expected %0d", ptr, 0); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected %b", in_ready, 1'b1); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_explicit();
        auto_mode = 1'b0; S = 2'b10; I = 4'h1; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL expl_in_ready got %b expected %b", in_ready, 1'b1); end
        tick();
        in_valid = 1'b0;
        checks++; if (lane_valid !== 4'b0100) begin errors++; $display("FAIL expl_lane_valid got %b expected %b", lane_valid, 4'b0100); end
        checks++; if (Y !== 16'h0100) begin errors++; $display("FAIL expl_Y got %h expected %h", Y, 16'h0100); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL expl_ptr got %0d expected %0d", ptr, 0); end
        lane_ack = 4'b0100;
        tick();
        lane_ack = 4'b0000;
        checks++; if (lane_valid !== 4'b0000) begin errors++; $display("FAIL expl_ack_valid got %b expected %b", lane_valid, 4'b0000); end
        checks++; if (Y !== 16'h0100) begin errors++; $display("FAIL expl_ack_hold got %h expected %h", Y, 16'h0100); end
    endtask

    task automatic test_auto_back_to_back();
        logic [W-1:0] vals [4];
        vals[0] = 4'hA; vals[1] = 4'h5; vals[2] = 4'hC; vals[3] = 4'h3;
        auto_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            I = vals[k]; in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL auto_ready_%0d got %b expected %b", k, in_ready, 1'b1); end
            checks++; if (ptr !== 2'(k)) begin errors++; $display("FAIL auto_ptr_%0d got %0d expected %0d", k, ptr, k); end
            tick();
        end
        I = 4'hF;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL auto_full_ready got %b expected %b", in_ready, 1'b0); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL auto_ptr_wrap got %0d expected %0d", ptr, 0); end
        checks++; if (lane_valid !== 4'b1111) begin errors++; $display("FAIL auto_lane_valid got %b expected %b", lane_valid, 4'b1111); end
        checks++; if (Y !== 16'h3C5A) begin errors++; $display("FAIL auto_Y got %h expected %h", Y, 16'h3C5A); end
        tick();
        checks++; if (Y !== 16'h3C5A) begin errors++; $display("FAIL stall_Y got %h expected %h", Y, 16'h3C5A); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL stall_ptr got %0d expected %0d", ptr, 0); end
        auto_mode = 1'b0; S = 2'b01;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_expl_ready got %b expected %b", in_ready, 1'b0); end
        in_valid = 1'b0;
    endtask

    task automatic test_ack_write();
        auto_mode = 1'b0; S = 2'b00; I = 4'h0; in_valid = 1'b1; lane_ack = 4'b0001;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ackwr_ready got %b expected %b", in_ready, 1'b1); end
        tick();
        in_valid = 1'b0; lane_ack = 4'b0000;
        checks++; if (lane_valid !== 4'b1111) begin errors++; $display("FAIL ackwr_valid got %b expected %b", lane_valid, 4'b1111); end
        checks++; if (Y !== 16'h3C50) begin errors++; $display("FAIL ackwr_Y got %h expected %h", Y, 16'h3C50); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL ackwr_ptr got %0d expected %0d", ptr, 0); end
    endtask

    task automatic test_multi_ack();
        lane_ack = 4'b1100;
        tick();
        checks++; if (lane_valid !== 4'b0011) begin errors++; $display("FAIL mack_valid1 got %b expected %b", lane_valid, 4'b0011); end
        lane_ack = 4'b1010;
        tick();
        lane_ack = 4'b0000;
        checks++; if (lane_valid !== 4'b0001) begin errors++; $display("FAIL mack_valid2 got %b expected %b", lane_valid, 4'b0001); end
        checks++; if (Y !== 16'h3C50) begin errors++; $display("FAIL mack_Y_hold got %h expected %h", Y, 16'h3C50); end
    endtask

    task automatic test_ptr_retain();
        auto_mode = 1'b1; I = 4'h7; in_valid = 1'b1; lane_ack = 4'b0001;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ptr_ackwr_ready got %b expected %b", in_ready, 1'b1); end
        tick();
        lane_ack = 4'b0000;
        checks++; if (ptr !== 2'd1) begin errors++; $display("FAIL ptr_adv got %0d expected %0d", ptr, 1); end
        auto_mode = 1'b0; S = 2'b11; I = 4'h9;
        tick();
        checks++; if (ptr !== 2'd1) begin errors++; $display("FAIL ptr_expl_hold got %0d expected %0d", ptr, 1); end
        checks++; if (lane_valid !== 4'b1001) begin errors++; $display("FAIL ptr_expl_valid got %b expected %b", lane_valid, 4'b1001); end
        auto_mode = 1'b1; I = 4'h6;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ptr_resume_ready got %b expected %b", in_ready, 1'b1); end
        tick();
        in_valid = 1'b0;
        checks++; if (ptr !== 2'd2) begin errors++; $display("FAIL ptr_resume got %0d expected %0d", ptr, 2); end
        checks++; if (lane_valid !== 4'b1011) begin errors++; $display("FAIL ptr_resume_valid got %b expected %b", lane_valid, 4'b1011); end
        checks++; if (Y !== 16'h9C67) begin errors++; $display("FAIL ptr_resume_Y got %h expected %h", Y, 16'h9C67); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (Y !== 16'h0000) begin errors++; $display("FAIL areset_Y got %h expected %h", Y, 16'h0000); end
        checks++; if (lane_valid !== 4'b0000) begin errors++; $display("FAIL areset_valid got %b expected %b", lane_valid, 4'b0000); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL areset_ptr got %0d expected %0d", ptr, 0); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef DEMUX_STALL_CNT_EN
    task automatic test_stall_cnt();
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL scnt_reset got %0d expected %0d", stall_cnt, 0); end
        auto_mode = 1'b0; S = 2'b00; I = 4'h1; in_valid = 1'b1;
        tick();
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL scnt_accept got %0d expected %0d", stall_cnt, 0); end
        repeat (3) tick();
        checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL scnt_three got %0d expected %0d", stall_cnt, 3); end
        repeat (300) tick();
        checks++; if (stall_cnt !== 8'd255) begin errors++; $display("FAIL scnt_sat got %0d expected %0d", stall_cnt, 255); end
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL scnt_clr got %0d expected %0d", stall_cnt, 0); end
        tick();
        in_valid = 1'b0;
        checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL scnt_after_clr got %0d expected %0d", stall_cnt, 1); end
        tick();
        checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL scnt_idle got %0d expected %0d", stall_cnt, 1); end
    endtask
`endif

    initial begin
        test_reset();
        test_explicit();
        test_auto_back_to_back();
        test_ack_write();
        test_multi_ack();
        test_ptr_retain();
        test_async_reset();
`ifdef DEMUX_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
